// File: rtl/muldiv_sequencer_if.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_if
//   Bundles the request/response signals between the EX stage and the
//   iterative multiply/divide unit.
//
//   Request side (driven by the EX stage / hazard unit):
//     start        request a new operation
//     op           00 MUL, 01 MULU, 10 DIV, 11 DIVU
//     src_a        multiplicand / dividend
//     src_b        multiplier / divisor
//     flush        abort the operation in flight
//   Response side (driven by the unit):
//     busy         operation in flight (CALC or FIX)
//     stall        hold IF/ID/EX this cycle
//     done         one-cycle pulse, hi/lo valid
//     div_by_zero  divide with zero divisor, valid with done
//     hi, lo       result halves
//     dbg_state    encoded FSM state, for observation only
//
//   Handshake: start is a request. It is consumed on a rising edge only
//   while the unit is in IDLE or DONE and flush is low; stall is raised
//   combinationally in the same cycle so the pipeline keeps the request's
//   instruction in EX until done pulses.
// -----------------------------------------------------------------------------
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             flush;
   logic             busy;
   logic             stall;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [1:0]       dbg_state;

   modport master (
      output start, op, src_a, src_b, flush,
      input  busy, stall, done, div_by_zero, hi, lo, dbg_state
   );

   modport slave (
      input  start, op, src_a, src_b, flush,
      output busy, stall, done, div_by_zero, hi, lo, dbg_state
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//   Iterative multiply/divide unit sitting beside the EX-stage ALU. One
//   add/subtract step per cycle: WIDTH steps in CALC, one sign-fix cycle in
//   FIX, then a one-cycle DONE that pulses done with hi/lo valid.
//
//   Ports:
//     clk   single clock, rising edge
//     rst   synchronous, active-high; discards any operation in flight
//     bus   muldiv_sequencer_if.slave (start/op/src_a/src_b/flush in,
//           busy/stall/done/div_by_zero/hi/lo/dbg_state out)
//
//   Datapath registers are shared between the two operations:
//     MUL: r_acc = upper product half, r_mq = multiplier shifting out /
//          lower product half shifting in, r_mcand = |multiplicand|
//     DIV: r_acc = partial remainder, r_mq = dividend shifting out /
//          quotient shifting in, r_mcand = |divisor|
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input logic               clk,
   input logic               rst,
   muldiv_sequencer_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [CW-1:0]     r_cnt;
   logic [WIDTH-1:0]  r_acc;
   logic [WIDTH-1:0]  r_mq;
   logic [WIDTH-1:0]  r_mcand;
   logic [WIDTH-1:0]  r_hi;
   logic [WIDTH-1:0]  r_lo;
   logic              r_is_div;
   logic              r_neg_res;
   logic              r_neg_rem;
   logic              r_dbz;

   logic              w_accepting;
   logic              w_accept;
   logic              w_signed;
   logic              w_op_div;
   logic              w_dbz;
   logic [WIDTH-1:0]  w_abs_a;
   logic [WIDTH-1:0]  w_abs_b;
   logic              w_last;
   logic [WIDTH:0]    w_mul_sum;
   logic [WIDTH:0]    w_div_shift;
   logic [WIDTH:0]    w_div_trial;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_neg;

   // Request decode
   assign w_accepting = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_accept    = w_accepting && bus.start && !bus.flush;
   assign w_signed    = ~bus.op[0];
   assign w_op_div    = bus.op[1];
   assign w_dbz       = w_op_div && (bus.src_b == '0);

   // Magnitudes for signed ops; -MIN wraps to MIN, which is the correct
   // unsigned magnitude.
   assign w_abs_a = (w_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
   assign w_abs_b = (w_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

   assign w_last = (r_cnt == CW'(WIDTH - 1));

   // One shift-add step: the carry out of the add becomes the new MSB of
   // the accumulator after the right shift.
   assign w_mul_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_mcand} : '0);

   // One restoring-division step: MSB of the trial result is the borrow.
   assign w_div_shift = {r_acc, r_mq[WIDTH-1]};
   assign w_div_trial = w_div_shift - {1'b0, r_mcand};

   assign w_prod     = {r_acc, r_mq};
   assign w_prod_neg = -w_prod;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
               w_next = w_dbz ? S_DONE : S_CALC;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_CALC: begin
            if (bus.flush) begin
               w_next = S_IDLE;
            end else if (w_last) begin
               w_next = S_FIX;
            end
         end
         S_FIX: begin
            w_next = bus.flush ? S_IDLE : S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_mq      <= '0;
         r_mcand   <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_dbz     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_cnt     <= '0;
                  r_acc     <= '0;
                  r_is_div  <= w_op_div;
                  r_neg_res <= w_signed && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
                  r_neg_rem <= w_signed && bus.src_a[WIDTH-1];
                  r_dbz     <= w_dbz;
                  if (w_op_div) begin
                     r_mq    <= w_abs_a;
                     r_mcand <= w_abs_b;
                  end else begin
                     r_mq    <= w_abs_b;
                     r_mcand <= w_abs_a;
                  end
                  // Divide by zero completes immediately with fixed results.
                  if (w_dbz) begin
                     r_hi <= bus.src_a;
                     r_lo <= '1;
                  end
               end
            end
            S_CALC: begin
               if (!bus.flush) begin
                  r_cnt <= r_cnt + CW'(1);
                  if (r_is_div) begin
                     if (!w_div_trial[WIDTH]) begin
                        r_acc <= w_div_trial[WIDTH-1:0];
                        r_mq  <= {r_mq[WIDTH-2:0], 1'b1};
                     end else begin
                        r_acc <= w_div_shift[WIDTH-1:0];
                        r_mq  <= {r_mq[WIDTH-2:0], 1'b0};
                     end
                  end else begin
                     r_acc <= w_mul_sum[WIDTH:1];
                     r_mq  <= {w_mul_sum[0], r_mq[WIDTH-1:1]};
                  end
               end
            end
            S_FIX: begin
               if (!bus.flush) begin
                  if (r_is_div) begin
                     r_lo <= r_neg_res ? -r_mq : r_mq;
                     r_hi <= r_neg_rem ? -r_acc : r_acc;
                  end else begin
                     {r_hi, r_lo} <= r_neg_res ? w_prod_neg : w_prod;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = (r_state == S_CALC) || (r_state == S_FIX);
   assign bus.done        = (r_state == S_DONE);
   assign bus.stall       = bus.busy || (bus.start && w_accepting);
   assign bus.div_by_zero = r_dbz;
   assign bus.hi          = r_hi;
   assign bus.lo          = r_lo;
   assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Directed bench for muldiv_sequencer. A cycle-level model (countdown to
//   done plus plain arithmetic results held in exp_q) is compared against
//   every DUT output on every cycle; literal values from hand calculation
//   pin the model on the key cases.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

   localparam int W = 32;

   // ---------------------------------------------------------------- clock/reset
   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   muldiv_sequencer_if #(.WIDTH(W)) bus();

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------------------------------------------------------- scoreboard
   logic [2*W-1:0] exp_q[$];
   int unsigned    m_left;
   logic           m_done;
   logic           m_dbz;
   logic [W-1:0]   m_hi;
   logic [W-1:0]   m_lo;

   int  n_vec;
   int  n_err;
   int  cyc;
   int  k_acc;
   int  done_cyc;
   int  stall_cnt;
   bit  seen_done;
   bit  chk_en;

   function automatic logic [2*W-1:0] model_res(input logic [1:0] o,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      logic signed [2*W-1:0] sa;
      logic signed [2*W-1:0] sb;
      int qa;
      int qb;
      case (o)
         2'd0: begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            return sa * sb;
         end
         2'd1: return {{W{1'b0}}, a} * {{W{1'b0}}, b};
         2'd2: begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               return {{W{1'b0}}, a};
            end
            qa = a;
            qb = b;
            return {32'(qa % qb), 32'(qa / qb)};
         end
         default: return {a % b, a / b};
      endcase
   endfunction

   task automatic check(input string name, input logic [2*W-1:0] act,
                        input logic [2*W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc + 1, act, exp);
      end
   endtask

   // Model advances at each rising edge on the inputs the DUT also samples.
   task automatic model_update();
      if (rst) begin
         m_left = 0;
         m_done = 1'b0;
         m_dbz  = 1'b0;
         m_hi   = '0;
         m_lo   = '0;
         exp_q.delete();
      end else if (m_left != 0) begin
         if (bus.flush) begin
            m_left = 0;
            m_done = 1'b0;
            void'(exp_q.pop_front());
         end else begin
            m_left--;
            m_done = (m_left == 0);
            if (m_done) {m_hi, m_lo} = exp_q.pop_front();
         end
      end else begin
         m_done = 1'b0;
         if (bus.start && !bus.flush) begin
            m_dbz = bus.op[1] && (bus.src_b == '0);
            if (m_dbz) begin
               m_done = 1'b1;
               m_hi   = bus.src_a;
               m_lo   = '1;
            end else begin
               m_left = W + 1;
               exp_q.push_back(model_res(bus.op, bus.src_a, bus.src_b));
            end
         end
      end
   endtask

   task automatic compare_all();
      if (!chk_en) return;
      check("busy",  64'(bus.busy),  64'(m_left != 0));
      check("stall", 64'(bus.stall), 64'((m_left != 0) || (bus.start && m_left == 0)));
      check("done",  64'(bus.done),  64'(m_done));
      check("div_by_zero", 64'(bus.div_by_zero), 64'(m_dbz));
      check("hi", 64'(bus.hi), 64'(m_hi));
      check("lo", 64'(bus.lo), 64'(m_lo));
      if (bus.done) begin
         seen_done = 1'b1;
         done_cyc  = cyc + 1;
      end
      if (bus.stall) stall_cnt++;
   endtask

   // One clock: compare mid-cycle, step the model on the edge, then return
   // just after the edge so new inputs never race the DUT.
   task automatic tick();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   // ---------------------------------------------------------------- drivers
   task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b);
      bus.start = 1'b1;
      bus.op    = o;
      bus.src_a = a;
      bus.src_b = b;
      tick();
      k_acc     = cyc;
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      seen_done = 1'b0;
      for (int i = 0; i < 60 && !seen_done; i++) tick();
      if (!seen_done) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: no done within 60 cycles of cycle %0d", k_acc);
      end
   endtask

   // ---------------------------------------------------------------- stimulus
   logic [1:0]   t_op[8] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd2, 2'd1, 2'd3};
   logic [W-1:0] t_a[8]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd12345, 32'd100,
                             32'd7, 32'hFFFF_FF9C, 32'hDEAD_BEEF, 32'd5};
   logic [W-1:0] t_b[8]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FD5A, 32'd7,
                             32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'h1234_5678, 32'd9};

   initial begin
      n_vec = 0; n_err = 0; cyc = 0; chk_en = 1'b0;
      stall_cnt = 0; seen_done = 1'b0; done_cyc = 0; k_acc = 0;
      m_left = 0; m_done = 1'b0; m_dbz = 1'b0; m_hi = '0; m_lo = '0;
      rst = 1'b1;
      bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'd0;
      bus.src_a = '0;   bus.src_b = '0;

      // Reset
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_hi",   64'(bus.hi), 64'd0);
      check("rst_lo",   64'(bus.lo), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      tick();

      // MULU all-ones squared
      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done();
      check("mulu_latency", 64'(done_cyc - k_acc), 64'd34);
      check("mulu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
      check("mulu_lo", 64'(bus.lo), 64'h0000_0001);

      // MUL -3*5 with stall window k..k+33
      stall_cnt = 0;
      issue(2'd0, 32'hFFFF_FFFD, 32'd5);
      wait_done();
      check("mul_stall_cycles", 64'(stall_cnt), 64'd34);
      check("mul_hi", 64'(bus.hi), 64'hFFFF_FFFF);
      check("mul_lo", 64'(bus.lo), 64'hFFFF_FFF1);

      // DIV -7/2 and DIVU 7/2
      issue(2'd2, 32'hFFFF_FFF9, 32'd2);
      wait_done();
      check("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
      check("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);
      issue(2'd3, 32'd7, 32'd2);
      wait_done();
      check("divu_lo", 64'(bus.lo), 64'd3);
      check("divu_hi", 64'(bus.hi), 64'd1);

      // DIVU by zero
      issue(2'd3, 32'd5, 32'd0);
      wait_done();
      check("dbz_latency", 64'(done_cyc - k_acc), 64'd1);
      check("dbz_flag", 64'(bus.div_by_zero), 64'd1);
      check("dbz_lo", 64'(bus.lo), 64'hFFFF_FFFF);
      check("dbz_hi", 64'(bus.hi), 64'd5);

      // Signed MIN / -1
      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done();
      check("minneg1_lo", 64'(bus.lo), 64'h8000_0000);
      check("minneg1_hi", 64'(bus.hi), 64'd0);
      check("minneg1_dbz", 64'(bus.div_by_zero), 64'd0);

      // Mixed-sign table, checked by the per-cycle model
      for (int i = 0; i < 8; i++) begin
         issue(t_op[i], t_a[i], t_b[i]);
         wait_done();
      end

      // Known prior results, then flush mid-CALC
      issue(2'd3, 32'd7, 32'd2);
      wait_done();
      issue(2'd0, 32'd1234, 32'd5678);
      for (int i = 0; i < 9; i++) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      check("flush_no_done", 64'(seen_done), 64'd0);
      check("flush_hi", 64'(bus.hi), 64'd1);
      check("flush_lo", 64'(bus.lo), 64'd3);

      // Start together with flush in IDLE is ignored
      bus.flush = 1'b1;
      issue(2'd1, 32'd9, 32'd9);
      bus.flush = 1'b0;
      tick();
      check("flush_start_busy", 64'(bus.busy), 64'd0);

      // Reset mid-operation
      issue(2'd1, 32'd77, 32'd88);
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_hi",    64'(bus.hi), 64'd0);
      check("midrst_lo",    64'(bus.lo), 64'd0);
      check("midrst_busy",  64'(bus.busy), 64'd0);
      check("midrst_stall", 64'(bus.stall), 64'd0);
      check("midrst_done",  64'(bus.done), 64'd0);
      tick();

      // Start held through CALC into DONE: second op accepted back-to-back
      bus.start = 1'b1; bus.op = 2'd1; bus.src_a = 32'd3; bus.src_b = 32'd4;
      tick();
      k_acc = cyc;
      bus.src_a = 32'd10; bus.src_b = 32'd20;
      wait_done();
      check("held_first_latency", 64'(done_cyc - k_acc), 64'd34);
      check("held_first_lo", 64'(bus.lo), 64'd12);
      k_acc = cyc;
      bus.start = 1'b0;
      wait_done();
      check("held_second_latency", 64'(done_cyc - k_acc), 64'd34);
      check("held_second_lo", 64'(bus.lo), 64'd200);
      check("held_second_hi", 64'(bus.hi), 64'd0);

      for (int i = 0; i < 3; i++) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
